// File: rtl/tour_pkg.sv
// Shared types for the knight's-tour command sequencer: headings, opcodes,
// sequencer states and the 16-bit cmd_proc command word.
package tour_pkg;

    typedef enum logic [7:0] {
        HDG_N = 8'h00,
        HDG_W = 8'h3F,
        HDG_S = 8'h7F,
        HDG_E = 8'hBF
    } heading_t;

    localparam logic [3:0] OPC_MOVE    = 4'b0100;
    localparam logic [3:0] OPC_MOVE_FF = 4'b0101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERT,
        HOLDV,
        HORZ,
        HOLDH
    } state_t;

    typedef struct packed {
        logic [3:0] opc;
        heading_t   hdg;
        logic [3:0] sq;
    } cmd_t;

    function automatic cmd_t mk_cmd(input logic ff, input heading_t hdg, input logic [3:0] sq);
        cmd_t c;
        c.opc = ff ? OPC_MOVE_FF : OPC_MOVE;
        c.hdg = hdg;
        c.sq  = sq;
        return c;
    endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Combinational decode of a one-hot knight move into its vertical and
// horizontal cmd_proc legs; any pattern that is not exactly one-hot is illegal.
module knight_move_decode
    import tour_pkg::*;
#(
    parameter bit VERT_FF = 1'b0,
    parameter bit HORZ_FF = 1'b1
) (
    input  logic [7:0]  move_i,
    output logic [15:0] vert_cmd_o,
    output logic [15:0] horz_cmd_o,
    output logic        illegal_o
);

    cmd_t vert;
    cmd_t horz;

    always_comb begin
        vert      = mk_cmd(VERT_FF, HDG_N, 4'd0);
        horz      = mk_cmd(HORZ_FF, HDG_N, 4'd0);
        illegal_o = 1'b0;
        case (move_i)
            8'h01: begin vert = mk_cmd(VERT_FF, HDG_N, 4'd2); horz = mk_cmd(HORZ_FF, HDG_E, 4'd1); end
            8'h02: begin vert = mk_cmd(VERT_FF, HDG_N, 4'd2); horz = mk_cmd(HORZ_FF, HDG_W, 4'd1); end
            8'h04: begin vert = mk_cmd(VERT_FF, HDG_N, 4'd1); horz = mk_cmd(HORZ_FF, HDG_W, 4'd2); end
            8'h08: begin vert = mk_cmd(VERT_FF, HDG_S, 4'd1); horz = mk_cmd(HORZ_FF, HDG_W, 4'd2); end
            8'h10: begin vert = mk_cmd(VERT_FF, HDG_S, 4'd2); horz = mk_cmd(HORZ_FF, HDG_W, 4'd1); end
            8'h20: begin vert = mk_cmd(VERT_FF, HDG_S, 4'd2); horz = mk_cmd(HORZ_FF, HDG_E, 4'd1); end
            8'h40: begin vert = mk_cmd(VERT_FF, HDG_S, 4'd1); horz = mk_cmd(HORZ_FF, HDG_E, 4'd2); end
            8'h80: begin vert = mk_cmd(VERT_FF, HDG_N, 4'd1); horz = mk_cmd(HORZ_FF, HDG_E, 4'd2); end
            default: illegal_o = 1'b1;
        endcase
    end

    assign vert_cmd_o = vert;
    assign horz_cmd_o = horz;

endmodule

// File: rtl/tour_cmd_seq.sv
// Replays a knight's-tour move list as vertical/horizontal command pairs to
// cmd_proc, muxed against the UART command path, with abort and bad-move handling.
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int         MAX_MOVES    = 24,
    parameter int         FANFARE_MODE = 1,
    parameter logic [7:0] RESP_DONE    = 8'hA5,
    parameter logic [7:0] RESP_BUSY    = 8'h5A,
    parameter logic [7:0] RESP_ABORT   = 8'hAB,
    localparam int        IDX_W        = $clog2(MAX_MOVES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [IDX_W-1:0] tour_len,
    input  logic             abort,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic             move_err
);

    localparam logic [IDX_W:0]   MAX_LEN = (IDX_W+1)'(MAX_MOVES);
    localparam logic [IDX_W:0]   LEN_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   len_q, len_d;
    logic             rdy_q, rdy_d;
    logic             err_q, err_d;
    logic             pend_q, pend_d;
    logic [15:0]      vert_q, horz_q;

    logic [15:0]      dec_vert, dec_horz;
    logic             dec_illegal;
    logic [IDX_W:0]   len_clamp;
    logic             last;
    logic             set_rdy;
    logic             abort_drop;

    knight_move_decode #(
        .VERT_FF (FANFARE_MODE == 2),
        .HORZ_FF (FANFARE_MODE != 0)
    ) u_dec (
        .move_i     (move),
        .vert_cmd_o (dec_vert),
        .horz_cmd_o (dec_horz),
        .illegal_o  (dec_illegal)
    );

    assign len_clamp = ({1'b0, tour_len} > MAX_LEN) ? MAX_LEN : {1'b0, tour_len};
    assign last      = (({1'b0, idx_q} + LEN_ONE) == len_q);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        err_d      = err_q;
        pend_d     = pend_q;
        abort_drop = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_tour) begin
                    idx_d = '0;
                    len_d = len_clamp;
                    err_d = 1'b0;
                    if (tour_len != '0) state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d    = IDLE;
                    abort_drop = 1'b1;
                end else if (dec_illegal) begin
                    err_d = 1'b1;
                    if (last) state_d = IDLE;
                    else      idx_d   = idx_q + IDX_ONE;
                end else begin
                    state_d = VERT;
                end
            end
            VERT: begin
                if (abort) begin
                    state_d    = IDLE;
                    abort_drop = 1'b1;
                end else if (clr_cmd_rdy) begin
                    state_d = HOLDV;
                end
            end
            HOLDV: begin
                if (send_resp) state_d = (abort || pend_q) ? IDLE : HORZ;
                else if (abort) pend_d = 1'b1;
            end
            HORZ: begin
                if (abort) begin
                    state_d    = IDLE;
                    abort_drop = 1'b1;
                end else if (clr_cmd_rdy) begin
                    state_d = HOLDH;
                end
            end
            HOLDH: begin
                if (send_resp) begin
                    if (abort || pend_q || last) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = LOAD;
                    end
                end else if (abort) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) pend_d = 1'b0;
        // Setting on entry to VERT/HORZ gives the 2-cycle start/next-move latency.
        set_rdy = (state_d == VERT) || (state_d == HORZ);
        if (clr_cmd_rdy || abort_drop) rdy_d = 1'b0;
        else if (set_rdy)              rdy_d = 1'b1;
        else                           rdy_d = rdy_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    // Leg commands are data only; they are always reloaded in LOAD before use.
    always_ff @(posedge clk) begin
        if (state_q == LOAD) begin
            vert_q <= dec_vert;
            horz_q <= dec_horz;
        end
    end

    always_comb begin
        if (state_q == IDLE) begin
            cmd     = cmd_UART;
            cmd_rdy = cmd_rdy_UART;
        end else begin
            cmd     = ((state_q == HORZ) || (state_q == HOLDH)) ? horz_q : vert_q;
            cmd_rdy = rdy_q;
        end
        if (pend_q)                                         resp = RESP_ABORT;
        else if ((state_q == IDLE) || ((state_q == HOLDH) && last)) resp = RESP_DONE;
        else                                                resp = RESP_BUSY;
    end

    assign mv_indx   = idx_q;
    assign tour_busy = (state_q != IDLE);
    assign move_err  = err_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq: a move-list model builds the expected
// leg commands and responses, and one compare process checks them each cycle.
module tb_tour_cmd_seq;

    localparam int MAX_MOVES = 24;
    localparam int FF_MODE   = 1;
    localparam int IDX_W     = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_tour;
    logic [IDX_W-1:0] tour_len;
    logic             abort;
    logic [7:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic [15:0]      cmd_UART;
    logic             cmd_rdy_UART;
    logic             clr_cmd_rdy;
    logic             send_resp;
    logic [15:0]      cmd;
    logic             cmd_rdy;
    logic [7:0]       resp;
    logic             tour_busy;
    logic             move_err;

    logic [7:0]  mlist [32];
    logic [15:0] exp_cmd [$];
    logic [7:0]  exp_resp [$];
    int          n_cmp = 0;
    int          n_err = 0;

    tour_cmd_seq #(
        .MAX_MOVES    (MAX_MOVES),
        .FANFARE_MODE (FF_MODE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_tour   (start_tour),
        .tour_len     (tour_len),
        .abort        (abort),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .resp         (resp),
        .tour_busy    (tour_busy),
        .move_err     (move_err)
    );

    always #5 clk = ~clk;

    assign move = mlist[mv_indx];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] leg_cmd(input bit ff, input logic [7:0] hdg, input int mag);
        logic [3:0] op;
        op = ff ? 4'h5 : 4'h4;
        return {op, hdg, 4'(mag)};
    endfunction

    // A tour of n moves is the list of legal moves in order, each a (dy,dx)
    // knight jump issued as a north/south leg then an east/west leg.
    task automatic build_exp(input int len_in, input int abort_leg);
        int dy [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
        int dx [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
        int len, legs, b;
        bit stop;
        exp_cmd.delete();
        exp_resp.delete();
        len  = (len_in > MAX_MOVES) ? MAX_MOVES : len_in;
        legs = 0;
        stop = 1'b0;
        for (int i = 0; i < len && !stop; i++) begin
            if ($countones(mlist[i]) == 1) begin
                b = 0;
                for (int k = 0; k < 8; k++) if (mlist[i][k]) b = k;
                exp_cmd.push_back(leg_cmd(FF_MODE == 2, (dy[b] > 0) ? 8'h00 : 8'h7F,
                                          (dy[b] < 0) ? -dy[b] : dy[b]));
                if (legs == abort_leg) begin
                    exp_resp.push_back(8'hAB);
                    stop = 1'b1;
                end else begin
                    exp_resp.push_back(8'h5A);
                    legs++;
                    exp_cmd.push_back(leg_cmd(FF_MODE != 0, (dx[b] > 0) ? 8'hBF : 8'h3F,
                                              (dx[b] < 0) ? -dx[b] : dx[b]));
                    if (legs == abort_leg) begin
                        exp_resp.push_back(8'hAB);
                        stop = 1'b1;
                    end else begin
                        exp_resp.push_back((i == len - 1) ? 8'hA5 : 8'h5A);
                        legs++;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tour_busy && clr_cmd_rdy) begin
                chk("leg_rdy", 32'(cmd_rdy), 32'd1);
                if (exp_cmd.size() == 0) chk("leg_extra", 32'(exp_cmd.size()), 32'd1);
                else                     chk("leg_cmd", 32'(cmd), 32'(exp_cmd.pop_front()));
            end
            if (tour_busy && send_resp) begin
                if (exp_resp.size() == 0) chk("resp_extra", 32'(exp_resp.size()), 32'd1);
                else                      chk("leg_resp", 32'(resp), 32'(exp_resp.pop_front()));
            end
            if (!tour_busy) begin
                chk("idle_cmd", 32'(cmd), 32'(cmd_UART));
                chk("idle_rdy", 32'(cmd_rdy), 32'(cmd_rdy_UART));
            end
        end
    end

    // cmd_proc stand-in: accept one leg, optionally inject abort/noise in HOLD.
    task automatic ack_leg(input bit do_abort, input bit noise, output bit got);
        int n;
        n   = 0;
        got = 1'b0;
        while (tour_busy && !cmd_rdy && n < 20) begin
            step();
            n++;
        end
        if (!tour_busy) return;
        if (!cmd_rdy) begin
            chk("leg_timeout", 32'(cmd_rdy), 32'd1);
            return;
        end
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        if (noise) begin
            cmd_rdy_UART = 1'b1;
            start_tour   = 1'b1;
            tour_len     = 5'd1;
            step();
            start_tour = 1'b0;
            chk("hold_rdy_mux", 32'(cmd_rdy), 32'd0);
            chk("hold_busy", 32'(tour_busy), 32'd1);
            cmd_rdy_UART = 1'b0;
        end
        if (do_abort) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
        end
        step();
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        got = 1'b1;
    endtask

    task automatic run_tour(input int len, input int abort_leg, input bit noise);
        int legs;
        bit got;
        build_exp(len, abort_leg);
        tour_len   = 5'(len);
        start_tour = 1'b1;
        step();
        start_tour = 1'b0;
        legs = 0;
        got  = 1'b1;
        while (got && legs < 100) begin
            ack_leg(legs == abort_leg, noise, got);
            if (got) legs++;
        end
        chk("end_busy", 32'(tour_busy), 32'd0);
        chk("cmds_left", 32'(exp_cmd.size()), 32'd0);
        chk("resps_left", 32'(exp_resp.size()), 32'd0);
    endtask

    initial begin
        bit got;
        rst_n        = 1'b0;
        start_tour   = 1'b0;
        tour_len     = '0;
        abort        = 1'b0;
        cmd_UART     = 16'h0000;
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        for (int i = 0; i < 32; i++) mlist[i] = 8'h01 << (i % 8);
        step();
        step();
        rst_n = 1'b1;
        step();

        chk("rst_busy", 32'(tour_busy), 32'd0);
        chk("rst_indx", 32'(mv_indx), 32'd0);
        chk("rst_err", 32'(move_err), 32'd0);
        chk("rst_rdy", 32'(cmd_rdy), 32'd0);
        chk("rst_resp", 32'(resp), 32'hA5);

        cmd_UART     = 16'h2000;
        cmd_rdy_UART = 1'b1;
        #1;
        chk("mux_cmd", 32'(cmd), 32'h2000);
        chk("mux_rdy", 32'(cmd_rdy), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_busy", 32'(tour_busy), 32'd0);
        cmd_rdy_UART = 1'b0;

        build_exp(24, -1);
        chk("model_v0", 32'(exp_cmd[0]), 32'h4002);
        chk("model_h0", 32'(exp_cmd[1]), 32'h5BF1);
        chk("model_n", 32'(exp_cmd.size()), 32'd48);

        run_tour(24, -1, 1'b0);
        chk("full_indx", 32'(mv_indx), 32'd23);
        chk("full_err", 32'(move_err), 32'd0);

        cmd_UART = 16'h1234;
        run_tour(3, -1, 1'b1);
        chk("short_indx", 32'(mv_indx), 32'd2);
        cmd_rdy_UART = 1'b1;
        #1;
        chk("short_mux_cmd", 32'(cmd), 32'h1234);
        chk("short_mux_rdy", 32'(cmd_rdy), 32'd1);
        cmd_rdy_UART = 1'b0;

        tour_len   = 5'd0;
        start_tour = 1'b1;
        step();
        start_tour = 1'b0;
        chk("len0_busy", 32'(tour_busy), 32'd0);

        run_tour(30, -1, 1'b0);
        chk("clamp_indx", 32'(mv_indx), 32'd23);

        mlist[2] = 8'h03;
        run_tour(5, -1, 1'b0);
        chk("illegal_err", 32'(move_err), 32'd1);
        chk("illegal_indx", 32'(mv_indx), 32'd4);
        mlist[2] = 8'h04;

        run_tour(24, 10, 1'b0);
        chk("abort_indx", 32'(mv_indx), 32'd5);
        chk("abort_err_clr", 32'(move_err), 32'd0);
        chk("abort_resp_idle", 32'(resp), 32'hA5);

        build_exp(24, -1);
        tour_len   = 5'd24;
        start_tour = 1'b1;
        step();
        start_tour = 1'b0;
        for (int l = 0; l < 3; l++) ack_leg(1'b0, 1'b0, got);
        for (int n = 0; n < 20 && !cmd_rdy; n++) step();
        chk("pre_rst_rdy", 32'(cmd_rdy), 32'd1);
        chk("pre_rst_indx", 32'(mv_indx), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rdy", 32'(cmd_rdy), 32'd0);
        chk("rst_mid_busy", 32'(tour_busy), 32'd0);
        chk("rst_mid_indx", 32'(mv_indx), 32'd0);
        exp_cmd.delete();
        exp_resp.delete();
        step();
        rst_n = 1'b1;
        step();
        run_tour(2, -1, 1'b0);
        chk("post_rst_indx", 32'(mv_indx), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
